// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the memory-access stage.
//   OP_LOAD / OP_STORE : major opcodes that touch data memory
//   F3_*               : funct3 access-size / signedness codes
//   mem_state_t        : memory-stage FSM states
//   f3_valid()         : funct3 legal for the given load/store opcode
//   mem_misaligned()   : access does not sit on its natural boundary
package riscv_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    HOLD
  } mem_state_t;

  // Loads accept all five size codes; stores only the signed-looking three.
  function automatic logic f3_valid(input logic load, input logic [2:0] f3);
    if (load) begin
      return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    end
    return f3 inside {F3_B, F3_H, F3_W};
  endfunction

  // funct3[1:0] encodes the size for both signed and unsigned variants.
  function automatic logic mem_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    unique case (f3[1:0])
      2'b01:   return addr_lo[0];
      2'b10:   return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks the addressed byte/halfword lane from the
// read word and sign- or zero-extends it to 32 bits.
//   rdata   : raw word returned by data memory
//   addr_lo : byte offset of the access within the word
//   funct3  : load size / signedness
//   ext     : extended load result
module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] ext
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    unique case (addr_lo)
      2'd0: byte_lane = rdata[7:0];
      2'd1: byte_lane = rdata[15:8];
      2'd2: byte_lane = rdata[23:16];
      2'd3: byte_lane = rdata[31:24];
      default: byte_lane = rdata[7:0];
    endcase
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    ext = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   ext = {24'h0, byte_lane};
      F3_H:    ext = {{16{half_lane[15]}}, half_lane};
      F3_HU:   ext = {16'h0, half_lane};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// RV32I memory-access stage. Passes non-memory results straight to
// writeback, runs loads/stores over a valid/ready data-memory port and
// stalls upstream while an access is outstanding.
//   req, reset_n          : clock (rising edge), async active-low reset
//   stall_in              : downstream stall
//   alu_*/result_in/...   : instruction from execute (result_in = address)
//   dmem_*                : registered data-memory request, ready/rdata reply
//   stall_out             : upstream stall while BUSY or HOLD
//   rd_write/rd_out/result_out : registered writeback
//   misaligned_out        : one-cycle misaligned-access pulse
module mem_access
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            req,
  input  logic            reset_n,
  input  logic            stall_in,
  input  logic [6:0]      alu_opcode_in,
  input  logic [2:0]      alu_funct3,
  input  logic [XLEN-1:0] result_in,
  input  logic [XLEN-1:0] rs2_value_in,
  input  logic [4:0]      rd_in,
  input  logic            rd_write_in,
  output logic            dmem_valid,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_wstrb,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            stall_out,
  output logic            rd_write,
  output logic [4:0]      rd_out,
  output logic [XLEN-1:0] result_out,
  output logic            misaligned_out
);

  mem_state_t state_q, state_d;

  logic            dmem_valid_q, dmem_valid_d;
  logic            dmem_we_q, dmem_we_d;
  logic [XLEN-1:0] dmem_addr_q, dmem_addr_d;
  logic [XLEN-1:0] dmem_wdata_q, dmem_wdata_d;
  logic [3:0]      dmem_wstrb_q, dmem_wstrb_d;
  logic            rd_write_q, rd_write_d;
  logic [4:0]      rd_out_q, rd_out_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            mis_q, mis_d;

  // Access context captured on acceptance; upstream inputs are not trusted
  // to be meaningful once the request is in flight.
  logic [4:0]      lat_rd_q, lat_rd_d;
  logic [2:0]      lat_f3_q, lat_f3_d;
  logic [1:0]      lat_lo_q, lat_lo_d;
  logic            lat_load_q, lat_load_d;
  logic [XLEN-1:0] hold_q, hold_d;

  logic            is_load, is_store, is_mem, misaligned;
  logic [XLEN-1:0] st_wdata;
  logic [3:0]      st_wstrb;
  logic [XLEN-1:0] load_ext;

  load_align u_load_align (
    .rdata   (dmem_rdata),
    .addr_lo (lat_lo_q),
    .funct3  (lat_f3_q),
    .ext     (load_ext)
  );

  // Decode of the incoming instruction and its store-side encoding.
  always_comb begin
    is_load    = alu_opcode_in == OP_LOAD;
    is_store   = alu_opcode_in == OP_STORE;
    is_mem     = (is_load || is_store) && f3_valid(is_load, alu_funct3);
    misaligned = mem_misaligned(alu_funct3, result_in[1:0]);

    case (alu_funct3[1:0])
      2'b00: begin
        st_wdata = {4{rs2_value_in[7:0]}};
        st_wstrb = 4'b0001 << result_in[1:0];
      end
      2'b01: begin
        st_wdata = {2{rs2_value_in[15:0]}};
        st_wstrb = 4'b0011 << result_in[1:0];
      end
      default: begin
        st_wdata = rs2_value_in;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    dmem_valid_d = dmem_valid_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    dmem_wstrb_d = dmem_wstrb_q;
    rd_write_d   = rd_write_q;
    rd_out_d     = rd_out_q;
    result_d     = result_q;
    mis_d        = 1'b0;
    lat_rd_d     = lat_rd_q;
    lat_f3_d     = lat_f3_q;
    lat_lo_d     = lat_lo_q;
    lat_load_d   = lat_load_q;
    hold_d       = hold_q;

    unique case (state_q)
      IDLE: begin
        if (!stall_in) begin
          if (is_mem && misaligned) begin
            mis_d      = 1'b1;
            rd_write_d = 1'b0;
          end else if (is_mem) begin
            lat_rd_d     = rd_in;
            lat_f3_d     = alu_funct3;
            lat_lo_d     = result_in[1:0];
            lat_load_d   = is_load;
            dmem_valid_d = 1'b1;
            dmem_we_d    = is_store;
            dmem_addr_d  = {result_in[XLEN-1:2], 2'b00};
            dmem_wdata_d = is_store ? st_wdata : '0;
            dmem_wstrb_d = is_store ? st_wstrb : 4'b0000;
            rd_write_d   = 1'b0;
            state_d      = BUSY;
          end else begin
            // Plain ALU ops, plus load/store opcodes with an illegal funct3.
            result_d   = result_in;
            rd_out_d   = rd_in;
            rd_write_d = rd_write_in && (rd_in != 5'd0) && !(is_load || is_store);
          end
        end
      end

      BUSY: begin
        if (dmem_ready) begin
          dmem_valid_d = 1'b0;
          if (!stall_in) begin
            if (lat_load_q) begin
              result_d = load_ext;
              rd_out_d = lat_rd_q;
            end
            rd_write_d = lat_load_q && (lat_rd_q != 5'd0);
            state_d    = IDLE;
          end else begin
            // rdata is only valid during the ready pulse, so park it.
            hold_d  = load_ext;
            state_d = HOLD;
          end
        end
      end

      HOLD: begin
        if (!stall_in) begin
          if (lat_load_q) begin
            result_d = hold_q;
            rd_out_d = lat_rd_q;
          end
          rd_write_d = lat_load_q && (lat_rd_q != 5'd0);
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge req or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      dmem_valid_q <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      dmem_wstrb_q <= 4'b0000;
      rd_write_q   <= 1'b0;
      rd_out_q     <= 5'd0;
      result_q     <= '0;
      mis_q        <= 1'b0;
      lat_rd_q     <= 5'd0;
      lat_f3_q     <= 3'b000;
      lat_lo_q     <= 2'b00;
      lat_load_q   <= 1'b0;
      hold_q       <= '0;
    end else begin
      state_q      <= state_d;
      dmem_valid_q <= dmem_valid_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_wstrb_q <= dmem_wstrb_d;
      rd_write_q   <= rd_write_d;
      rd_out_q     <= rd_out_d;
      result_q     <= result_d;
      mis_q        <= mis_d;
      lat_rd_q     <= lat_rd_d;
      lat_f3_q     <= lat_f3_d;
      lat_lo_q     <= lat_lo_d;
      lat_load_q   <= lat_load_d;
      hold_q       <= hold_d;
    end
  end

  assign dmem_valid     = dmem_valid_q;
  assign dmem_we        = dmem_we_q;
  assign dmem_addr      = dmem_addr_q;
  assign dmem_wdata     = dmem_wdata_q;
  assign dmem_wstrb     = dmem_wstrb_q;
  assign rd_write       = rd_write_q;
  assign rd_out         = rd_out_q;
  assign result_out     = result_q;
  assign misaligned_out = mis_q;
  assign stall_out      = state_q != IDLE;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed vector table, hand-written
// stall/reset sequences, and randomized ops against a byte-level memory model.
module tb_mem_access;
  import riscv_pkg::*;

  localparam logic [6:0] OP_ALU = 7'b0110011;

  logic        req = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall_in = 1'b0;
  logic [6:0]  alu_opcode_in = OP_ALU;
  logic [2:0]  alu_funct3 = 3'b000;
  logic [31:0] result_in = 32'h0;
  logic [31:0] rs2_value_in = 32'h0;
  logic [4:0]  rd_in = 5'd0;
  logic        rd_write_in = 1'b0;
  logic        dmem_valid, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;
  logic        stall_out, rd_write;
  logic [4:0]  rd_out;
  logic [31:0] result_out;
  logic        misaligned_out;

  mem_access #(.XLEN(32)) dut (
    .req            (req),
    .reset_n        (reset_n),
    .stall_in       (stall_in),
    .alu_opcode_in  (alu_opcode_in),
    .alu_funct3     (alu_funct3),
    .result_in      (result_in),
    .rs2_value_in   (rs2_value_in),
    .rd_in          (rd_in),
    .rd_write_in    (rd_write_in),
    .dmem_valid     (dmem_valid),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_wstrb     (dmem_wstrb),
    .dmem_ready     (dmem_ready),
    .dmem_rdata     (dmem_rdata),
    .stall_out      (stall_out),
    .rd_write       (rd_write),
    .rd_out         (rd_out),
    .result_out     (result_out),
    .misaligned_out (misaligned_out)
  );

  always #5 req = ~req;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Memory responder: word array written through the DUT's strobes.
  logic [31:0] mem_word [16];
  logic [7:0]  ref_mem  [64];
  bit          mem_auto = 1'b1;
  int          wait_cnt = 0;

  always @(negedge req) begin
    if (mem_auto) begin
      if (dmem_ready) begin
        dmem_ready = 1'b0;
      end else if (dmem_valid) begin
        if (wait_cnt > 0) begin
          wait_cnt--;
        end else begin
          dmem_rdata = mem_word[dmem_addr[5:2]];
          if (dmem_we) begin
            for (int j = 0; j < 4; j++) begin
              if (dmem_wstrb[j]) mem_word[dmem_addr[5:2]][8*j +: 8] = dmem_wdata[8*j +: 8];
            end
          end
          dmem_ready = 1'b1;
        end
      end
    end
  end

  task automatic drive_nop();
    alu_opcode_in = OP_ALU;
    rd_write_in   = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    chk1({name, " dmem_valid"}, dmem_valid, 1'b0);
    chk1({name, " dmem_we"}, dmem_we, 1'b0);
    chk32({name, " dmem_addr"}, dmem_addr, 32'h0);
    chk32({name, " dmem_wdata"}, dmem_wdata, 32'h0);
    chk32({name, " dmem_wstrb"}, {28'h0, dmem_wstrb}, 32'h0);
    chk1({name, " stall_out"}, stall_out, 1'b0);
    chk1({name, " rd_write"}, rd_write, 1'b0);
    chk32({name, " rd_out"}, {27'h0, rd_out}, 32'h0);
    chk32({name, " result_out"}, result_out, 32'h0);
    chk1({name, " misaligned_out"}, misaligned_out, 1'b0);
  endtask

  // Called at a negedge; returns at a negedge with a NOP driven.
  task automatic run_op(input string name, input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] rs2, input logic [4:0] rd,
                        input logic rdw, input int w, input logic exp_req, input logic exp_we,
                        input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb,
                        input logic exp_mis, input logic chk_res, input logic [31:0] exp_res,
                        input logic exp_rdw);
    bit done;
    wait_cnt      = w;
    stall_in      = 1'b0;
    alu_opcode_in = op;
    alu_funct3    = f3;
    result_in     = addr;
    rs2_value_in  = rs2;
    rd_in         = rd;
    rd_write_in   = rdw;
    @(posedge req); #1;
    chk1({name, " misaligned_out"}, misaligned_out, exp_mis);
    chk1({name, " dmem_valid"}, dmem_valid, exp_req);
    if (exp_req) begin
      chk1({name, " dmem_we"}, dmem_we, exp_we);
      chk32({name, " dmem_addr"}, dmem_addr, {addr[31:2], 2'b00});
      chk32({name, " dmem_wstrb"}, {28'h0, dmem_wstrb}, {28'h0, exp_wstrb});
      if (exp_we) chk32({name, " dmem_wdata"}, dmem_wdata, exp_wdata);
      chk1({name, " stall_out busy"}, stall_out, 1'b1);
      chk1({name, " rd_write bubble"}, rd_write, 1'b0);
      done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
        @(posedge req); #1;
        if (!stall_out) begin
          done = 1'b1;
        end else begin
          chk1({name, " dmem_valid held"}, dmem_valid, 1'b1);
          chk32({name, " dmem_addr held"}, dmem_addr, {addr[31:2], 2'b00});
        end
      end
      if (!done) chk1({name, " timeout stall_out"}, stall_out, 1'b0);
      chk1({name, " dmem_valid done"}, dmem_valid, 1'b0);
    end
    if (chk_res) begin
      chk32({name, " result_out"}, result_out, exp_res);
      chk32({name, " rd_out"}, {27'h0, rd_out}, {27'h0, rd});
    end
    chk1({name, " rd_write"}, rd_write, exp_rdw);
    chk1({name, " stall_out idle"}, stall_out, 1'b0);
    @(negedge req);
    drive_nop();
  endtask

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        rdw;
    logic [31:0] word;
    int          w;
    logic        exp_req;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    logic        exp_mis;
    logic        chk_res;
    logic [31:0] exp_res;
    logic        exp_rdw;
  } vec_t;

  vec_t tbl [14];

  initial begin
    logic [31:0] addr, rs2, val, exp_wdata;
    logic [3:0]  exp_wstrb;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  op;
    logic        rdw, mis, ld, sgn;
    int          kind, size, a6, off;
    logic [2:0]  ld_f3 [5];
    ld_f3 = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};

    //            name       op        f3     addr          rs2           rd     rdw   word          w  req   we    wdata         wstrb    mis   res   exp_res       rdw
    tbl[0]  = '{"add",      OP_ALU,   F3_B,  32'h00001234, 32'h0,        5'd5,  1'b1, 32'h0,        0, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b0, 1'b1, 32'h00001234, 1'b1};
    tbl[1]  = '{"add_x0",   OP_ALU,   F3_B,  32'h00000055, 32'h0,        5'd0,  1'b1, 32'h0,        0, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b0, 1'b1, 32'h00000055, 1'b0};
    tbl[2]  = '{"sb",       OP_STORE, F3_B,  32'h00001003, 32'h000000AB, 5'd0,  1'b0, 32'h0,        2, 1'b1, 1'b1, 32'hABABABAB, 4'b1000, 1'b0, 1'b0, 32'h0,        1'b0};
    tbl[3]  = '{"lb",       OP_LOAD,  F3_B,  32'h00002001, 32'h0,        5'd7,  1'b1, 32'h000080FF, 0, 1'b1, 1'b0, 32'h0,        4'b0000, 1'b0, 1'b1, 32'hFFFFFF80, 1'b1};
    tbl[4]  = '{"lbu",      OP_LOAD,  F3_BU, 32'h00002001, 32'h0,        5'd7,  1'b1, 32'h000080FF, 1, 1'b1, 1'b0, 32'h0,        4'b0000, 1'b0, 1'b1, 32'h00000080, 1'b1};
    tbl[5]  = '{"lw_mis",   OP_LOAD,  F3_W,  32'h00003002, 32'h0,        5'd8,  1'b1, 32'h0,        0, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b1, 1'b0, 32'h0,        1'b0};
    tbl[6]  = '{"sh",       OP_STORE, F3_H,  32'h00002002, 32'h1234CAFE, 5'd0,  1'b0, 32'h0,        0, 1'b1, 1'b1, 32'hCAFECAFE, 4'b1100, 1'b0, 1'b0, 32'h0,        1'b0};
    tbl[7]  = '{"sw",       OP_STORE, F3_W,  32'h00002004, 32'hDEADBEEF, 5'd0,  1'b0, 32'h0,        1, 1'b1, 1'b1, 32'hDEADBEEF, 4'b1111, 1'b0, 1'b0, 32'h0,        1'b0};
    tbl[8]  = '{"lh",       OP_LOAD,  F3_H,  32'h00002006, 32'h0,        5'd3,  1'b1, 32'h80017FFF, 0, 1'b1, 1'b0, 32'h0,        4'b0000, 1'b0, 1'b1, 32'hFFFF8001, 1'b1};
    tbl[9]  = '{"lhu",      OP_LOAD,  F3_HU, 32'h00002006, 32'h0,        5'd3,  1'b1, 32'h80017FFF, 3, 1'b1, 1'b0, 32'h0,        4'b0000, 1'b0, 1'b1, 32'h00008001, 1'b1};
    tbl[10] = '{"lw_x0",    OP_LOAD,  F3_W,  32'h00002008, 32'h0,        5'd0,  1'b1, 32'h12345678, 0, 1'b1, 1'b0, 32'h0,        4'b0000, 1'b0, 1'b1, 32'h12345678, 1'b0};
    tbl[11] = '{"ld_badf3", OP_LOAD,  3'b011, 32'h00000040, 32'h0,       5'd9,  1'b1, 32'h0,        0, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b0, 1'b1, 32'h00000040, 1'b0};
    tbl[12] = '{"lh_mis",   OP_LOAD,  F3_H,  32'h00002001, 32'h0,        5'd4,  1'b1, 32'h0,        0, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b1, 1'b0, 32'h0,        1'b0};
    tbl[13] = '{"st_badf3", OP_STORE, F3_BU, 32'h00000044, 32'h11111111, 5'd6,  1'b1, 32'h0,        0, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b0, 1'b1, 32'h00000044, 1'b0};

    for (int k = 0; k < 16; k++) mem_word[k] = 32'h0;

    // Reset state
    #12;
    check_all_zero("reset");
    @(negedge req);
    reset_n = 1'b1;
    @(posedge req); #1;
    check_all_zero("after reset idle");
    @(negedge req);

    // Directed vectors
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].op == OP_LOAD) mem_word[tbl[i].addr[5:2]] = tbl[i].word;
      run_op(tbl[i].name, tbl[i].op, tbl[i].f3, tbl[i].addr, tbl[i].rs2, tbl[i].rd, tbl[i].rdw,
             tbl[i].w, tbl[i].exp_req, tbl[i].exp_we, tbl[i].exp_wdata, tbl[i].exp_wstrb,
             tbl[i].exp_mis, tbl[i].chk_res, tbl[i].exp_res, tbl[i].exp_rdw);
    end

    // Misaligned pulse lasts one cycle only
    run_op("lw_mis2", OP_LOAD, F3_W, 32'h00003001, 32'h0, 5'd2, 1'b1, 0, 1'b0, 1'b0, 32'h0,
           4'b0000, 1'b1, 1'b0, 32'h0, 1'b0);
    @(posedge req); #1;
    chk1("mis pulse width", misaligned_out, 1'b0);
    chk1("mis no request", dmem_valid, 1'b0);
    @(negedge req);

    // Stall during load: ready arrives while stalled, result parked in HOLD
    run_op("add_pre", OP_ALU, F3_B, 32'h0000A5A5, 32'h0, 5'd4, 1'b1, 0, 1'b0, 1'b0, 32'h0,
           4'b0000, 1'b0, 1'b1, 32'h0000A5A5, 1'b1);
    mem_auto      = 1'b0;
    alu_opcode_in = OP_LOAD;
    alu_funct3    = F3_W;
    result_in     = 32'h00002010;
    rd_in         = 5'd12;
    rd_write_in   = 1'b1;
    @(posedge req); #1;
    chk1("hold valid", dmem_valid, 1'b1);
    chk1("hold stall_out", stall_out, 1'b1);
    @(negedge req);
    stall_in   = 1'b1;
    dmem_rdata = 32'hCAFEF00D;
    dmem_ready = 1'b1;
    @(posedge req); #1;
    chk1("hold entry stall_out", stall_out, 1'b1);
    chk1("hold entry valid", dmem_valid, 1'b0);
    chk32("hold entry result_out", result_out, 32'h0000A5A5);
    chk1("hold entry rd_write", rd_write, 1'b0);
    @(negedge req);
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    for (int c = 0; c < 2; c++) begin
      @(posedge req); #1;
      chk1("hold wait stall_out", stall_out, 1'b1);
      chk32("hold wait result_out", result_out, 32'h0000A5A5);
    end
    @(negedge req);
    stall_in = 1'b0;
    @(posedge req); #1;
    chk32("hold exit result_out", result_out, 32'hCAFEF00D);
    chk32("hold exit rd_out", {27'h0, rd_out}, 32'd12);
    chk1("hold exit rd_write", rd_write, 1'b1);
    chk1("hold exit stall_out", stall_out, 1'b0);
    @(negedge req);
    drive_nop();
    mem_auto = 1'b1;

    // Reset mid-BUSY; the late ready must not produce a writeback
    mem_auto      = 1'b0;
    alu_opcode_in = OP_LOAD;
    alu_funct3    = F3_W;
    result_in     = 32'h00002014;
    rd_in         = 5'd13;
    rd_write_in   = 1'b1;
    @(posedge req); #1;
    chk1("rst busy valid", dmem_valid, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("rst async");
    @(negedge req);
    drive_nop();
    reset_n    = 1'b1;
    dmem_rdata = 32'h0000FFFF;
    dmem_ready = 1'b1;
    @(posedge req); #1;
    chk1("late ready rd_write", rd_write, 1'b0);
    chk1("late ready valid", dmem_valid, 1'b0);
    chk1("late ready stall_out", stall_out, 1'b0);
    @(negedge req);
    dmem_ready = 1'b0;
    mem_auto   = 1'b1;

    // Randomized ops against a byte-addressed reference memory
    for (int k = 0; k < 16; k++) begin
      mem_word[k] = $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4*k + b] = mem_word[k][8*b +: 8];
    end
    for (int n = 0; n < 250; n++) begin
      kind = $urandom_range(0, 9);
      addr = $urandom;
      rs2  = $urandom;
      rd   = 5'($urandom_range(0, 31));
      rdw  = 1'($urandom_range(0, 1));
      ld   = 1'b0;
      if (kind <= 3) begin
        op = OP_LOAD;
        f3 = ld_f3[$urandom_range(0, 4)];
        ld = 1'b1;
      end else if (kind <= 6) begin
        op = OP_STORE;
        f3 = 3'($urandom_range(0, 2));
      end else if (kind == 7) begin
        op = OP_LOAD;
        f3 = 3'($urandom_range(0, 2)) == 3'd0 ? 3'b011 : 3'b11_0 | 3'($urandom_range(0, 1));
      end else if (kind == 8) begin
        op = OP_STORE;
        f3 = 3'($urandom_range(3, 7));
      end else begin
        op = OP_ALU;
        f3 = 3'($urandom_range(0, 7));
      end
      size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      if ($urandom_range(0, 1) == 1) addr = addr & ~32'(size - 1);
      a6  = int'(addr[5:0]);
      off = int'(addr[1:0]);
      mis = (off % size) != 0;

      if (kind <= 6) begin
        if (mis) begin
          run_op("rand_mis", op, f3, addr, rs2, rd, rdw, 0, 1'b0, 1'b0, 32'h0, 4'b0000, 1'b1,
                 1'b0, 32'h0, 1'b0);
        end else if (ld) begin
          val = 32'h0;
          for (int i = 0; i < size; i++) val[8*i +: 8] = ref_mem[a6 + i];
          sgn = !f3[2];
          if (sgn && size < 4 && val[8*size-1])
            for (int i = size; i < 4; i++) val[8*i +: 8] = 8'hFF;
          run_op("rand_load", op, f3, addr, rs2, rd, rdw, $urandom_range(0, 3), 1'b1, 1'b0,
                 32'h0, 4'b0000, 1'b0, 1'b1, val, rd != 5'd0);
        end else begin
          exp_wstrb = 4'b0000;
          for (int i = 0; i < size; i++) exp_wstrb[off + i] = 1'b1;
          for (int j = 0; j < 4; j++) exp_wdata[8*j +: 8] = rs2[8*(j % size) +: 8];
          run_op("rand_store", op, f3, addr, rs2, rd, rdw, $urandom_range(0, 3), 1'b1, 1'b1,
                 exp_wdata, exp_wstrb, 1'b0, 1'b0, 32'h0, 1'b0);
          for (int i = 0; i < size; i++) ref_mem[a6 + i] = rs2[8*i +: 8];
        end
      end else begin
        run_op("rand_pass", op, f3, addr, rs2, rd, rdw, 0, 1'b0, 1'b0, 32'h0, 4'b0000, 1'b0,
               1'b1, addr, (op == OP_ALU) && rdw && (rd != 5'd0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
